// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and issues imem requests.
// Buffers fetched words in a small queue and presents the head {inst, PC+4} to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        ld,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   inst_q [QDEPTH];
  logic [31:0]   pc4_q  [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   fpc4;
  logic          push;
  logic          pop;
  logic          head_new;
  logic [CW-1:0] count_n;
  logic [PW-1:0] rd_ptr_n;
  logic [PW-1:0] wr_ptr_n;

  // Queue bookkeeping; a redirect flushes everything and suppresses the pop.
  always_comb begin
    fpc4     = fpc + 32'd4;
    push     = (state == REQ) && imem_ack && !redirect;
    pop      = ld && valid_out && !redirect;
    head_new = push && (count == CW'(pop));
    count_n  = count + CW'(push) - CW'(pop);
    rd_ptr_n = rd_ptr + PW'(pop);
    wr_ptr_n = wr_ptr + PW'(push);
    if (redirect) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      valid_out <= 1'b0;
      inst_out  <= 32'h0;
      pc4_out   <= 32'h0;
    end else begin
      count  <= count_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      if (push) begin
        inst_q[wr_ptr] <= imem_rdata;
        pc4_q[wr_ptr]  <= fpc4;
      end

      // Outputs mirror the post-update head; a word pushed into an empty queue bypasses the array.
      valid_out <= (count_n != '0);
      if (count_n == '0) begin
        inst_out <= 32'h0;
        pc4_out  <= 32'h0;
      end else if (head_new) begin
        inst_out <= imem_rdata;
        pc4_out  <= fpc4;
      end else begin
        inst_out <= inst_q[rd_ptr_n];
        pc4_out  <= pc4_q[rd_ptr_n];
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            fpc       <= redirect_pc;
            imem_addr <= redirect_pc;
            imem_req  <= 1'b0;
          end else if (count < CW'(QDEPTH)) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fpc;
          end else begin
            imem_req  <= 1'b0;
            imem_addr <= fpc;
          end
        end
        REQ: begin
          if (redirect) begin
            fpc <= redirect_pc;
            if (imem_ack) begin
              state     <= IDLE;
              imem_req  <= 1'b0;
              imem_addr <= redirect_pc;
            end else begin
              // Stale request stays on the bus until memory answers it.
              state <= DROP;
            end
          end else if (imem_ack) begin
            fpc       <= fpc4;
            imem_addr <= fpc4;
            if (count_n < CW'(QDEPTH)) begin
              imem_req <= 1'b1;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            fpc <= redirect_pc;
          end
          if (imem_ack) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= redirect ? redirect_pc : fpc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected {inst, pc4} entries are queued as stimulus
// is set up and popped by a monitor whenever IF/ID accepts the head entry.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ld;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
  logic        valid_out;

  logic auto_ack;
  logic man_ack;
  logic mon_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ld          (ld),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_out    (inst_out),
    .pc4_out     (pc4_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory model: zero-wait (ack follows req) or manually acked.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = data_fn(imem_addr);

  // Monitor: empty queue must show nop outputs; each accepted head is compared to the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!valid_out) begin
        vectors++;
        if (inst_out !== 32'h0 || pc4_out !== 32'h0) begin
          miscompares++;
          $display("FAIL empty_outputs: inst_out=%h pc4_out=%h required 0/0", inst_out, pc4_out);
        end
      end else if (ld && !redirect) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pop: inst_out=%h pc4_out=%h, no entry expected", inst_out, pc4_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (inst_out !== e.inst || pc4_out !== e.pc4) begin
            miscompares++;
            $display("FAIL head_entry: inst_out=%h pc4_out=%h required inst=%h pc4=%h",
                     inst_out, pc4_out, e.inst, e.pc4);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc4);
    exp_t e;
    e.inst = data_fn(pc4 - 32'd4);
    e.pc4  = pc4;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    rst         = 1'b1;
    ld          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    auto_ack    = 1'b0;
    man_ack     = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    ld = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries still expected after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: got %b required 0", imem_req);
    end
    vectors++;
    if (imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr: got %h required 0", imem_addr);
    end
    vectors++;
    if (valid_out !== 1'b0 || inst_out !== 32'h0 || pc4_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b inst=%h pc4=%h required 0/0/0", valid_out, inst_out, pc4_out);
    end
  endtask

  task automatic test_stream();
    do_reset();
    auto_ack = 1'b1;
    ld       = 1'b1;
    for (int i = 1; i <= 8; i++) push_exp(32'(i * 4));
    cyc();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL stream_first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    cyc();
    vectors++;
    if (imem_addr !== 32'h4 || valid_out !== 1'b1) begin
      miscompares++; $display("FAIL stream_cycle2: addr=%h valid=%b required 4/1", imem_addr, valid_out);
    end
    drain(20);
  endtask

  task automatic test_stall();
    do_reset();
    auto_ack = 1'b1;
    repeat (6) cyc();
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL stall_req: got %b required 0", imem_req);
    end
    vectors++;
    if (valid_out !== 1'b1 || pc4_out !== 32'h4 || inst_out !== data_fn(32'h0)) begin
      miscompares++;
      $display("FAIL stall_hold: valid=%b pc4=%h inst=%h required 1/4/%h", valid_out, pc4_out, inst_out, data_fn(32'h0));
    end
    for (int i = 1; i <= 4; i++) push_exp(32'(i * 4));
    ld = 1'b1;
    drain(30);
  endtask

  task automatic test_delayed_redirect();
    do_reset();
    ld = 1'b1;
    cyc();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_hold: req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, valid_out);
    end
    cyc();
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0;
    vectors++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0) begin
      miscompares++; $display("FAIL drop_discard: req=%b valid=%b required 0/0", imem_req, valid_out);
    end
    cyc();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++; $display("FAIL redirect_addr: req=%b addr=%h required 1/100", imem_req, imem_addr);
    end
    push_exp(32'h104);
    push_exp(32'h108);
    push_exp(32'h10C);
    auto_ack = 1'b1;
    drain(20);
  endtask

  task automatic test_redirect_on_ack();
    do_reset();
    auto_ack = 1'b1;
    ld       = 1'b1;
    push_exp(32'h4);
    cyc();
    cyc();
    cyc();
    vectors++;
    if (imem_addr !== 32'h8) begin
      miscompares++; $display("FAIL ack_redirect_addr: got %h required 8", imem_addr);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || imem_req !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ack_redirect_flush: valid=%b req=%b pending=%0d required 0/0/0", valid_out, imem_req, exp_q.size());
    end
    push_exp(32'h204);
    push_exp(32'h208);
    cyc();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      miscompares++; $display("FAIL ack_redirect_next: req=%b addr=%h required 1/200", imem_req, imem_addr);
    end
    drain(20);
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    ld = 1'b1;
    cyc();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL midreset_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst     = 1'b0;
    man_ack = 1'b1;
    vectors++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_state: req=%b valid=%b addr=%h required 0/0/0", imem_req, valid_out, imem_addr);
    end
    cyc();
    man_ack = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1) begin
      miscompares++; $display("FAIL late_ack_ignored: valid=%b req=%b required 0/1", valid_out, imem_req);
    end
    cyc();
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++; $display("FAIL late_ack_no_push: valid=%b required 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    auto_ack = 1'b1;
    repeat (5) cyc();
    vectors++;
    if (valid_out !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++; $display("FAIL full_queue: valid=%b req=%b required 1/0", valid_out, imem_req);
    end
    for (int i = 1; i <= 12; i++) push_exp(32'(i * 4));
    ld = 1'b1;
    drain(60);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    auto_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL idle_redirect_req: got %b required 0", imem_req);
    end
    cyc();
    vectors++;
    if (imem_addr !== 32'hFFFF_FFF8 || imem_req !== 1'b1) begin
      miscompares++; $display("FAIL wrap_addr: req=%b addr=%h required 1/fffffff8", imem_req, imem_addr);
    end
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    ld = 1'b1;
    drain(30);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_delayed_redirect();
    test_redirect_on_ack();
    test_reset_mid_req();
    test_back_to_back();
    test_pc_wrap();
    mon_en = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
